// File: rtl/mem_access_if.sv
// Bus between the sequencer (master) and the memory responder (slave).
// Carries the selected address, the read/write strobes, the data-bus byte
// and the responder's status and LED outputs.
interface mem_access_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] address;
  logic              addr_sel;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic              busy;
  logic              done;
  logic              err;
  logic              led_rd;
  logic              led_wr;

  modport master (
    output address, addr_sel, mem_rd, mem_wr, data_in,
    input  data_out, data_oe, busy, done, err, led_rd, led_wr
  );

  modport slave (
    input  address, addr_sel, mem_rd, mem_wr, data_in,
    output data_out, data_oe, busy, done, err, led_rd, led_wr
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory responder at the far end of the address bus. It accepts a single
// read or write per strobe, waits a fixed relay-settle time, then either
// presents the stored byte or commits the latched byte and pulses done.
// Upper address bits are ignored, so addresses alias modulo the depth.
module mem_access_unit #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 16,
  parameter int DEPTH_LOG2    = 8,
  parameter int ACCESS_CYCLES = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  mem_access_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RDHOLD, WRHOLD} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t                state;
  logic [3:0]            cnt;
  logic                  op_wr;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];

  logic req_rd;
  logic req_wr;
  logic req_both;
  logic strobe_held;
  logic complete;
  logic mem_we;
  logic unused_addr_bits;

  assign req_rd   = bus.addr_sel &  bus.mem_rd & ~bus.mem_wr;
  assign req_wr   = bus.addr_sel & ~bus.mem_rd &  bus.mem_wr;
  assign req_both = bus.addr_sel &  bus.mem_rd &  bus.mem_wr;

  // Only the strobe of the accepted operation keeps an access alive.
  assign strobe_held = bus.addr_sel & (op_wr ? bus.mem_wr : bus.mem_rd);
  assign complete    = (state == WAIT) && strobe_held && (cnt == 4'd0);
  assign mem_we      = complete & op_wr;

  assign unused_addr_bits = ^bus.address[ADDR_W-1:DEPTH_LOG2];

  // Control FSM with registered status, LED and read-data outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      op_wr        <= 1'b0;
      bus.data_out <= '0;
      bus.data_oe  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.led_rd   <= 1'b0;
      bus.led_wr   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_rd || req_wr) begin
            state      <= WAIT;
            cnt        <= CNT_INIT;
            op_wr      <= req_wr;
            bus.busy   <= 1'b1;
            bus.led_rd <= req_rd;
            bus.led_wr <= req_wr;
          end else if (req_both) begin
            bus.err <= 1'b1;
          end
        end
        WAIT: begin
          if (!strobe_held) begin
            // Abort: the sequencer withdrew before the access settled.
            state      <= IDLE;
            bus.busy   <= 1'b0;
            bus.led_rd <= 1'b0;
            bus.led_wr <= 1'b0;
          end else if (cnt == 4'd0) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            if (op_wr) begin
              state <= WRHOLD;
            end else begin
              state        <= RDHOLD;
              bus.data_out <= mem[addr_q];
              bus.data_oe  <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RDHOLD: begin
          if (!(bus.addr_sel && bus.mem_rd)) begin
            state       <= IDLE;
            bus.data_oe <= 1'b0;
            bus.led_rd  <= 1'b0;
          end
        end
        WRHOLD: begin
          if (!(bus.addr_sel && bus.mem_wr)) begin
            state      <= IDLE;
            bus.led_wr <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address and write data are captured once at acceptance and then frozen.
  always_ff @(posedge clock) begin
    if (state == IDLE && (req_rd || req_wr)) begin
      addr_q  <= bus.address[DEPTH_LOG2-1:0];
      wdata_q <= bus.data_in;
    end
  end

  // Storage array; deliberately unreset so contents survive reset_n.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed accesses push expected completions
// into a scoreboard queue; a monitor pops and checks on every done/err.
module tb_mem_access_unit;

  localparam int AC = 3;
  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clock;
  logic reset_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb [$];

  mem_access_if #(.DATA_W(8), .ADDR_W(16)) bus ();

  mem_access_unit #(
    .DATA_W(8), .ADDR_W(16), .DEPTH_LOG2(8), .ACCESS_CYCLES(AC)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every done or err must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n === 1'b1 && (bus.done === 1'b1 || bus.err === 1'b1)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: done=%0b err=%0b with nothing pending (cycle %0d)",
                 bus.done, bus.err, cyc);
      end else begin
        e = sb.pop_front();
        chk("sb_cycle", cyc, e.cyc);
        if (bus.err === 1'b1) begin
          chk("sb_kind", K_ERR, e.kind);
        end else begin
          chk("sb_kind", bus.led_wr ? K_WR : K_RD, e.kind);
          if (e.kind == K_RD) begin
            chk("sb_data_oe", bus.data_oe, 1);
            chk("sb_data_out", bus.data_out, e.data);
          end
        end
      end
    end
  end

  task automatic release_bus();
    bus.addr_sel = 1'b0;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
  endtask

  // One complete access with cycle-exact timing checks and a hold phase.
  task automatic do_access(input bit wr, input logic [15:0] a, input logic [7:0] d,
                           input int hold);
    @(negedge clock);
    bus.address  = a;
    bus.data_in  = wr ? d : 8'h00;
    bus.addr_sel = 1'b1;
    bus.mem_wr   = wr;
    bus.mem_rd   = !wr;
    sb.push_back('{kind: wr ? K_WR : K_RD, data: d, cyc: cyc + 1 + AC});
    for (int i = 1; i <= AC; i++) begin
      @(negedge clock);
      if (i == 1) begin
        bus.address = ~a;
        bus.data_in = ~d;
      end
      chk("wait_busy", bus.busy, 1);
      chk("wait_no_done", bus.done, 0);
      chk("wait_led", wr ? bus.led_wr : bus.led_rd, 1);
    end
    @(negedge clock);
    chk("done_pulse", bus.done, 1);
    chk("busy_fall", bus.busy, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_no_done", bus.done, 0);
      if (!wr) begin
        chk("hold_data_oe", bus.data_oe, 1);
        chk("hold_data_out", bus.data_out, d);
      end
    end
    release_bus();
    @(negedge clock);
    chk("rel_data_oe", bus.data_oe, 0);
    chk("rel_led_rd", bus.led_rd, 0);
    chk("rel_led_wr", bus.led_wr, 0);
    chk("rel_busy", bus.busy, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_out"}, bus.data_out, 0);
    chk({tag, "_data_oe"}, bus.data_oe, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_led_rd"}, bus.led_rd, 0);
    chk({tag, "_led_wr"}, bus.led_wr, 0);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.address = 16'h0000;
    bus.data_in = 8'h00;
    release_bus();
    repeat (2) @(negedge clock);
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);
    chk_all_zero("post_reset");

    // Basic write then read-back.
    do_access(1'b1, 16'h0012, 8'h5A, 2);
    do_access(1'b0, 16'h0012, 8'h5A, 3);

    // Aliasing: upper address bits are ignored.
    do_access(1'b1, 16'h1234, 8'hA5, 1);
    do_access(1'b0, 16'h0034, 8'hA5, 2);

    // Abort a write by dropping mem_wr in the second WAIT cycle.
    @(negedge clock);
    bus.address  = 16'h0012;
    bus.data_in  = 8'hFF;
    bus.addr_sel = 1'b1;
    bus.mem_wr   = 1'b1;
    @(negedge clock);
    chk("abort_busy", bus.busy, 1);
    @(negedge clock);
    bus.mem_wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("abort_no_done", bus.done, 0);
      chk("abort_busy_low", bus.busy, 0);
    end
    release_bus();
    do_access(1'b0, 16'h0012, 8'h5A, 1);

    // Both strobes together: one err pulse, nothing starts.
    @(negedge clock);
    bus.address  = 16'h0012;
    bus.data_in  = 8'h00;
    bus.addr_sel = 1'b1;
    bus.mem_rd   = 1'b1;
    bus.mem_wr   = 1'b1;
    sb.push_back('{kind: K_ERR, data: 8'h00, cyc: cyc + 1});
    @(negedge clock);
    chk("both_err", bus.err, 1);
    chk("both_busy", bus.busy, 0);
    release_bus();
    @(negedge clock);
    chk("both_err_width", bus.err, 0);
    chk("both_busy_after", bus.busy, 0);
    do_access(1'b0, 16'h0012, 8'h5A, 1);
    do_access(1'b0, 16'h0034, 8'hA5, 1);

    // Asynchronous reset in the middle of a read.
    @(negedge clock);
    bus.address  = 16'h0034;
    bus.addr_sel = 1'b1;
    bus.mem_rd   = 1'b1;
    repeat (2) @(negedge clock);
    chk("pre_reset_busy", bus.busy, 1);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("async_reset");
    release_bus();
    @(negedge clock);
    chk_all_zero("in_reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    chk("after_reset_done", bus.done, 0);
    do_access(1'b0, 16'h0034, 8'hA5, 1);

    // Held read strobe: exactly one done, then a fresh one after re-assert.
    do_access(1'b0, 16'h0034, 8'hA5, 17);
    do_access(1'b0, 16'h0034, 8'hA5, 1);

    repeat (3) @(negedge clock);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
